// File: rtl/freq_gate_controller.sv
// rtl/freq_gate_controller.sv - gate window sequencer and auto-ranger for the BCD frequency counter
// Auto-ranging is built only when FREQ_AUTORANGE_EN is defined; otherwise the gate is fixed at CLK_HZ cycles.
module freq_gate_controller #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       eden,
  input  logic       ovf,
  input  logic [3:0] msd,
  output logic       cnt_inc,
  output logic       cnt_clr,
  output logic       latch,
  output logic [1:0] range,
  output logic       over
);

  localparam int CW = $clog2(CLK_HZ + 1);
  localparam logic [CW-1:0] N0 = CW'(CLK_HZ);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_GATE  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] gate_cnt_q, gate_cnt_d;
  logic [1:0]    r_q, r_d;
  logic          over_q, over_d;
  logic          ovf_seen_q, ovf_seen_d;
  logic          eden_s1_q, eden_s2_q, eden_prev_q, rise_q;

  logic          in_clear, in_gate, in_latch;
  logic          ovf_flag;
  logic [1:0]    r_next;
  logic [CW-1:0] gate_len;

  assign in_clear = (state_q == ST_CLEAR);
  assign in_gate  = (state_q == ST_GATE);
  assign in_latch = (state_q == ST_LATCH);

  // An ovf arriving in the LATCH cycle itself still counts toward this measurement.
  assign ovf_flag = ovf_seen_q | ovf;

`ifdef FREQ_AUTORANGE_EN
  localparam logic [CW-1:0] N1 = CW'(CLK_HZ / 10);
  localparam logic [CW-1:0] N2 = CW'(CLK_HZ / 100);

  always_comb begin
    case (r_q)
      2'd1:    gate_len = N1;
      2'd2:    gate_len = N2;
      default: gate_len = N0;
    endcase
  end

  always_comb begin
    r_next = r_q;
    if (ovf_flag) begin
      if (r_q < 2'd2) r_next = r_q + 2'd1;
    end else if ((msd == 4'd0) && (r_q != 2'd0)) begin
      r_next = r_q - 2'd1;
    end
  end
`else
  logic unused_msd;
  assign unused_msd = ^msd;
  assign gate_len   = N0;
  assign r_next     = 2'd0;
`endif

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    r_d        = r_q;
    over_d     = over_q;
    ovf_seen_d = ovf_seen_q;

    if ((in_gate || in_latch) && ovf) ovf_seen_d = 1'b1;

    case (state_q)
      ST_CLEAR: begin
        ovf_seen_d = 1'b0;
        gate_cnt_d = gate_len - CW'(1);
        state_d    = ST_GATE;
      end
      ST_GATE: begin
        if (gate_cnt_q == '0) begin
          state_d = ST_LATCH;
        end else begin
          gate_cnt_d = gate_cnt_q - CW'(1);
        end
      end
      ST_LATCH: begin
        over_d  = ovf_flag;
        r_d     = r_next;
        state_d = ST_CLEAR;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      gate_cnt_q  <= '0;
      r_q         <= 2'd0;
      over_q      <= 1'b0;
      ovf_seen_q  <= 1'b0;
      eden_s1_q   <= 1'b0;
      eden_s2_q   <= 1'b0;
      eden_prev_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_cnt_q  <= gate_cnt_d;
      r_q         <= r_d;
      over_q      <= over_d;
      ovf_seen_q  <= ovf_seen_d;
      eden_s1_q   <= eden;
      eden_s2_q   <= eden_s1_q;
      eden_prev_q <= eden_s2_q;
      rise_q      <= eden_s2_q & ~eden_prev_q;
    end
  end

  // Gating on the current state keeps cnt_inc disjoint from cnt_clr and latch.
  assign cnt_inc = rise_q & in_gate;
  assign cnt_clr = in_clear;
  assign latch   = in_latch;
  assign range   = r_q;
  assign over    = over_q;

endmodule

// File: tb/tb_freq_gate_controller.sv
// tb/tb_freq_gate_controller.sv - directed bench for freq_gate_controller at CLK_HZ=1000
module tb_freq_gate_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       eden;
  logic       ovf;
  logic [3:0] msd;
  logic       cnt_inc, cnt_clr, latch, over;
  logic [1:0] range;

  int total = 0;
  int bad = 0;
  int inc_count = 0;
  int len, incs;

  freq_gate_controller #(.CLK_HZ(1000)) dut (
    .clk(clk), .reset(reset), .eden(eden), .ovf(ovf), .msd(msd),
    .cnt_inc(cnt_inc), .cnt_clr(cnt_clr), .latch(latch),
    .range(range), .over(over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cnt_inc === 1'b1) inc_count <= inc_count + 1;
  end

  always @(negedge clk) begin
    chk("exclusive", ((int'(cnt_inc) + int'(cnt_clr) + int'(latch)) <= 1), 1);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Starts in a CLEAR cycle, runs one gate, returns in the following CLEAR cycle.
  // eden_mode: 0 idle, 1 period-20 square wave, 2 single rise at gate cycle eden_at.
  task automatic measure(input int ovf_at, input logic [3:0] msd_v, input int eden_mode,
                         input int eden_at, output int gate_len, output int n_inc);
    int base;
    chk("clear_at_start", cnt_clr, 1);
    msd = msd_v;
    base = inc_count;
    gate_len = 0;
    cyc();
    while (latch !== 1'b1 && gate_len < 2000) begin
      ovf = (gate_len == ovf_at);
      case (eden_mode)
        1:       eden = (((gate_len + 1) / 10) % 2) == 1;
        2:       eden = (gate_len + 1) >= eden_at;
        default: eden = 1'b0;
      endcase
      cyc();
      gate_len++;
    end
    ovf = 1'b0;
    eden = 1'b0;
    cyc();
    chk("latch_one_cycle", latch, 0);
    n_inc = inc_count - base;
  endtask

  task automatic reset_mid_gate(input int at_cycle);
    for (int i = 0; i < at_cycle; i++) cyc();
    reset = 1'b1;
    #1;
    chk("rst_cnt_clr", cnt_clr, 1);
    chk("rst_latch", latch, 0);
    chk("rst_range", range, 0);
    chk("rst_over", over, 0);
    chk("rst_cnt_inc", cnt_inc, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_no_latch", latch, 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    eden = 1'b0;
    ovf = 1'b0;
    msd = 4'd0;
    repeat (3) cyc();
    chk("reset_cnt_clr", cnt_clr, 1);
    chk("reset_latch", latch, 0);
    chk("reset_cnt_inc", cnt_inc, 0);
    chk("reset_range", range, 0);
    chk("reset_over", over, 0);
    reset = 1'b0;

    measure(-1, 4'd0, 1, 0, len, incs);
    chk("m1_len", len, 1000);
    chk("m1_incs", incs, 50);
    chk("m1_over", over, 0);
    chk("m1_range", range, 0);

`ifdef FREQ_AUTORANGE_EN
    measure(500, 4'd0, 0, 0, len, incs);
    chk("m2_len", len, 1000);
    chk("m2_over", over, 1);
    chk("m2_range", range, 1);

    measure(-1, 4'd3, 0, 0, len, incs);
    chk("m3_len", len, 100);
    chk("m3_over", over, 0);
    chk("m3_range", range, 1);

    measure(-1, 4'd0, 0, 0, len, incs);
    chk("m4_len", len, 100);
    chk("m4_over", over, 0);
    chk("m4_range", range, 0);

    measure(5, 4'd0, 0, 0, len, incs);
    chk("m5_len", len, 1000);
    chk("m5_over", over, 1);
    chk("m5_range", range, 1);

    measure(50, 4'd0, 0, 0, len, incs);
    chk("m6_len", len, 100);
    chk("m6_over", over, 1);
    chk("m6_range", range, 2);

    measure(9, 4'd0, 0, 0, len, incs);
    chk("m7_len", len, 10);
    chk("m7_over", over, 1);
    chk("m7_range", range, 2);

    measure(-1, 4'd0, 2, 7, len, incs);
    chk("m8_len", len, 10);
    chk("m8_last_gate_edge", incs, 1);
    chk("m8_over", over, 0);
    chk("m8_range", range, 1);

    measure(-1, 4'd3, 2, 98, len, incs);
    chk("m9_len", len, 100);
    chk("m9_latch_edge", incs, 0);
    chk("m9_over", over, 0);
    chk("m9_range", range, 1);

    measure(20, 4'd0, 0, 0, len, incs);
    chk("m10_len", len, 100);
    chk("m10_over", over, 1);
    chk("m10_range", range, 2);

    reset_mid_gate(5);
`else
    measure(500, 4'd0, 0, 0, len, incs);
    chk("m2_len", len, 1000);
    chk("m2_over", over, 1);
    chk("m2_range", range, 0);

    measure(999, 4'd0, 0, 0, len, incs);
    chk("m3_len", len, 1000);
    chk("m3_over", over, 1);
    chk("m3_range", range, 0);

    measure(-1, 4'd0, 2, 997, len, incs);
    chk("m4_len", len, 1000);
    chk("m4_last_gate_edge", incs, 1);
    chk("m4_over", over, 0);

    measure(-1, 4'd0, 2, 998, len, incs);
    chk("m5_latch_edge", incs, 0);
    chk("m5_range", range, 0);

    measure(5, 4'd0, 0, 0, len, incs);
    chk("m6_len", len, 1000);
    chk("m6_over", over, 1);
    chk("m6_range", range, 0);

    reset_mid_gate(500);
`endif

    measure(-1, 4'd0, 0, 0, len, incs);
    chk("post_rst_len", len, 1000);
    chk("post_rst_over", over, 0);
    chk("post_rst_range", range, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_gate_controller.md
# freq_gate_controller

Measurement sequencer for the frequency counter. It owns the gate window, conditions the raw `eden` input into one-clock count pulses, and clears and latches the four-digit BCD counter chain. It auto-ranges the gate time (1 s / 0.1 s / 0.01 s) from the chain's overflow carry and most-significant digit. It sits between the board input and the `bcdCount` cascade and replaces the free-running one-second divider as the source of clear and latch.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz; must be a multiple of 100 and ≥ 100.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `eden`  in  1  raw external signal under measurement, asynchronous to `clk`.
- `ovf`  in  1  carry-out of digit 3 of the BCD chain; high for one `clk` when the chain wraps 9999→0000.
- `msd`  in  4  current BCD value of digit 3.
- `cnt_inc`  out  1  one-`clk` increment pulse to digit 0.
- `cnt_clr`  out  1  synchronous clear to all digits.
- `latch`  out  1  one-`clk` strobe; display registers capture the digits on it.
- `range`  out  2  active gate range r ∈ {0,1,2}; display uses it for decimal-point placement.
- `over`  out  1  overrange flag for the currently latched value.

## Operation
- Input conditioning: `eden` passes through a 2-flop synchronizer, then a rising-edge detector that compares against the previous synchronized value.
- `cnt_inc` = detected rising edge AND state == GATE. Edges in any other state are dropped.
- Gate length N_r: N_0 = CLK_HZ, N_1 = CLK_HZ/10, N_2 = CLK_HZ/100 cycles. The gate counter width must be sufficient for N_0.
- FSM states:
  - CLEAR: 1 cycle; `cnt_clr`=1; clears the sticky `ovf_seen`; goes to GATE.
  - GATE: exactly N_r cycles, with r sampled on entry; goes to LATCH.
  - LATCH: 1 cycle; `latch`=1; `over` ← `ovf_seen`; range decision; goes to CLEAR.
- `ovf_seen` is set by `ovf`=1 in GATE or LATCH. It is cleared only in CLEAR. If set and clear coincide, clear wins.
- Range decision at LATCH (update takes effect on the edge ending LATCH):
  - `ovf_seen`=1 and r<2: r+1.
  - `ovf_seen`=1 and r=2: hold at 2. `over` still reports 1.
  - `ovf_seen`=0, `msd`==0, and r>0: r−1.
  - All other cases: hold.
- `range` changes only on that edge. A gate in progress never changes length.

## Timing
- Reset values: state CLEAR, r=0, `range`=0, `over`=0, `latch`=0, `cnt_inc`=0, sync/edge flops 0, gate counter 0, `ovf_seen`=0. `cnt_clr`=1 while reset is asserted (state decode).
- After reset release: cycle 0 is CLEAR, cycles 1…N_0 are GATE, cycle N_0+1 is LATCH. The measurement period is N_r+2 cycles.
- Latency from an `eden` rise (setup-met) to `cnt_inc`: 3 clk edges. Rising edges closer than 2 clk apart are not guaranteed to be counted.
- The last `cnt_inc` can occur in the final GATE cycle. Digits and `msd` are final during LATCH.
- `ovf` is expected in the same cycle as the `cnt_inc` that caused it, or one cycle later; both are captured.
- Reset asserted mid-operation immediately forces reset values. No `latch` is produced for the aborted gate.
- `cnt_clr`, `latch`, and `cnt_inc` are mutually exclusive in every cycle.

## Configuration
- `FREQ_AUTORANGE_EN` defined: auto-ranging as described.
- Undefined: r is fixed at 0, `range` is constantly 0, and the gate is always N_0. `ovf_seen`/`over` behave identically and flag overflow only. `msd` is ignored.

## Test plan
All scenarios use CLK_HZ=1000 (N_0=1000, N_1=100, N_2=10) with `FREQ_AUTORANGE_EN` defined unless noted.
- Reset, then toggle `eden` with period 20 clk → exactly 50 `cnt_inc` pulses between `cnt_clr` (cycle 0) and `latch` (cycle 1001). With `msd`=0, `range` stays 0 and `over`=0.
- At r=0, pulse `ovf` once mid-gate → at LATCH `over`=1 and `range`→1. The next GATE lasts 100 cycles (`latch` 102 cycles after the previous one). The following gate without `ovf`, and with `msd`=3, gives `over`=0 and `range` held at 1.
- At r=1 with `msd`=0 and no `ovf` at LATCH → `range`→0 and the next gate is 1000 cycles.
- Force r=2 and pulse `ovf` → `range` stays 2 and `over`=1. Repeat with `FREQ_AUTORANGE_EN` undefined → `range`=0 throughout, `over`=1, and the gate is always 1000 cycles.
- Assert `reset` at GATE cycle 500 for 3 cycles → outputs return to reset values immediately. No `latch` pulse occurs, and the next `latch` arrives 1001 cycles after release.
- Boundary: an `eden` rise whose edge reaches the detector in the first LATCH cycle → no `cnt_inc`. An edge reaching it in the last GATE cycle → counted.
